// File: rtl/shift_sequencer.sv
// shift_sequencer: runs a 16-bit shift (SLL, SRA or ROR) as three registered
// stages. The 4-bit amount is split into base-3 digits (d0, d1, d2). The
// stages then shift by d0*1, d1*3 and d2*9 in turn. The result is held in
// DONE until the consumer takes it.
module shift_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [3:0]       in_amount,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  // Operation encodings
  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b01;
  localparam logic [1:0] OP_ROR  = 2'b10;

  // Controller states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S1   = 3'd1;
  localparam logic [2:0] ST_S3   = 3'd2;
  localparam logic [2:0] ST_S9   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [WIDTH-1:0] r_work;
  logic [1:0]       r_op;
  logic [1:0]       r_d0;
  logic [1:0]       r_d1;
  logic [1:0]       r_d2;

  logic             w_accept;
  logic             w_stage_en;
  logic [1:0]       w_d0;
  logic [1:0]       w_d1;
  logic [1:0]       w_d2;
  logic [3:0]       w_rem;
  logic [4:0]       w_k;
  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_stage;

  // Handshake and status flags are decoded from the registered state only.
  // This keeps any input-to-output combinational path out of the block.
  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign out_result = r_work;

  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_stage_en = (r_state == ST_S1) || (r_state == ST_S3) || (r_state == ST_S9);

  // Base-2 to base-3 conversion of the amount (0..15). d2 is 0 or 1.
  // The remainder 0..8 then splits into d1 (0..2) and d0 (0..2).
  always_comb begin
    w_d2  = 2'd0;
    w_rem = in_amount;
    w_d1  = 2'd0;
    w_d0  = 2'd0;
    if (in_amount >= 4'd9) begin
      w_d2  = 2'd1;
      w_rem = in_amount - 4'd9;
    end
    if (w_rem >= 4'd6) begin
      w_d1 = 2'd2;
      w_d0 = w_rem[1:0] - 2'd2;      // rem 6..8 -> 0..2
    end else if (w_rem >= 4'd3) begin
      w_d1 = 2'd1;
      w_d0 = w_rem[1:0] - 2'd3;      // rem 3..5 -> 0..2 (mod-4 arithmetic)
    end else begin
      w_d1 = 2'd0;
      w_d0 = w_rem[1:0];
    end
  end

  // Select this stage's shift count: the digit weighted by 1, 3 or 9.
  always_comb begin
    w_k = 5'd0;
    case (r_state)
      ST_S1:   w_k = {3'b000, r_d0};
      ST_S3:   w_k = {3'b000, r_d1} * 5'd3;
      ST_S9:   w_k = {3'b000, r_d2} * 5'd9;
      default: w_k = 5'd0;
    endcase
  end

  // SLL fills the low bits with zeros.
  // SRA replicates bit 15 of the current working value.
  assign w_sll = r_work << w_k;
  assign w_sra = WIDTH'($signed(r_work) >>> w_k);

  // ROR: each output bit reads the working register at (bit + k) mod 16.
  // 4-bit index arithmetic wraps modulo 16 on its own.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ror
      assign w_ror[gi] = r_work[4'(gi) + w_k[3:0]];
    end
  endgenerate

  // Per-stage result chosen by the latched op. Op 11 passes the value through.
  always_comb begin
    w_stage = r_work;
    case (r_op)
      OP_SLL:  w_stage = w_sll;
      OP_SRA:  w_stage = w_sra;
      OP_ROR:  w_stage = w_ror;
      default: w_stage = r_work;
    endcase
  end

  // Next-state logic. Every accepted operation walks all three stages,
  // so latency stays constant.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_S1;
      ST_S1:   w_state_next = ST_S3;
      ST_S3:   w_state_next = ST_S9;
      ST_S9:   w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register. Reset from any state discards the operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand, op and digit capture on accept, then working-register updates per stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_op   <= 2'd0;
      r_d0   <= 2'd0;
      r_d1   <= 2'd0;
      r_d2   <= 2'd0;
    end else if (w_accept) begin
      r_work <= in_value;
      r_op   <= in_op;
      r_d0   <= w_d0;
      r_d1   <= w_d1;
      r_d2   <= w_d2;
    end else if (w_stage_en) begin
      r_work <= w_stage;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: directed and randomized operations checked
// against a single-step shift reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [3:0]  in_amount;
  logic [15:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_amount  (in_amount),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference: one shift by the full amount, straight from the op definitions.
  function automatic logic [15:0] model(input logic [1:0] op, input int amt, input logic [15:0] v);
    logic [31:0] dbl;
    case (op)
      2'b00:   return v << amt;
      2'b01:   return 16'($signed(v) >>> amt);
      2'b10: begin
        dbl = {v, v} >> amt;
        return dbl[15:0];
      end
      default: return v;
    endcase
  endfunction

  // Issue one operation and run it up to DONE.
  // Checks the latency, the status flags and the result.
  task automatic launch(input logic [1:0] op, input logic [3:0] amt,
                        input logic [15:0] val, input string tag);
    logic [15:0] exp;
    int cyc;
    exp = model(op, int'(amt), val);
    check($sformatf("%s_idle_ready", tag), 16'(in_ready), 16'd1);
    in_op = op; in_amount = amt; in_value = val; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble the inputs after accept; they must not affect the operation.
    in_valid  = 1'b0;
    in_op     = 2'($urandom);
    in_amount = 4'($urandom);
    in_value  = 16'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      check($sformatf("%s_ready_low_c%0d", tag, cyc), 16'(in_ready), 16'd0);
      check($sformatf("%s_busy_c%0d", tag, cyc), 16'(busy), 16'd1);
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s_latency", tag), 16'(cyc), 16'd3);
    check($sformatf("%s_ready_done", tag), 16'(in_ready), 16'd0);
    check($sformatf("%s_result", tag), out_result, exp);
    $display("txn %s op=%0d amt=%0d val=0x%h result=0x%h exp=0x%h", tag, op, amt, val, out_result, exp);
  endtask

  // Take the result and confirm the return to IDLE.
  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("%s_valid_after_xfer", tag), 16'(out_valid), 16'd0);
    check($sformatf("%s_ready_after_xfer", tag), 16'(in_ready), 16'd1);
  endtask

  initial begin
    logic [15:0] held;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_amount = 4'd0; in_value = 16'd0; out_ready = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_result", out_result, 16'h0000);

    // Directed cases
    launch(2'b00, 4'd15, 16'h0001, "sll_1_15"); check("sll_1_15_const", out_result, 16'h8000); take("sll_1_15");
    launch(2'b01, 4'd15, 16'h8000, "sra_neg");  check("sra_neg_const", out_result, 16'hFFFF); take("sra_neg");
    launch(2'b01, 4'd4,  16'h7F00, "sra_pos");  check("sra_pos_const", out_result, 16'h07F0); take("sra_pos");
    launch(2'b10, 4'd4,  16'h1234, "ror4");     check("ror4_const", out_result, 16'h4123); take("ror4");
    launch(2'b10, 4'd0,  16'h1234, "ror0");     check("ror0_const", out_result, 16'h1234); take("ror0");
    launch(2'b10, 4'd9,  16'h1234, "ror9");     check("ror9_const", out_result, 16'h1A09); take("ror9");
    launch(2'b10, 4'd8,  16'h1234, "ror8");     check("ror8_const", out_result, 16'h3412); take("ror8");

    // Sweep all ops over all amounts with random operands
    for (int op = 0; op < 4; op++) begin
      for (int a = 0; a < 16; a++) begin
        launch(2'(op), 4'(a), 16'($urandom), $sformatf("sweep_op%0d_a%0d", op, a));
        take($sformatf("sweep_op%0d_a%0d", op, a));
      end
    end

    // Backpressure: hold the result 10 cycles and poke in_valid meanwhile
    launch(2'b10, 4'd5, 16'hA5C3, "bp");
    held = out_result;
    in_op = 2'b00; in_amount = 4'd1; in_value = 16'h0F0F;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 4);
      @(posedge clk); #1;
      check($sformatf("bp_valid_c%0d", i), 16'(out_valid), 16'd1);
      check($sformatf("bp_result_c%0d", i), out_result, held);
      check($sformatf("bp_ready_c%0d", i), 16'(in_ready), 16'd0);
    end
    in_valid = 1'b0;
    check("bp_result_model", out_result, model(2'b10, 5, 16'hA5C3));
    take("bp");
    check("bp_idle_busy", 16'(busy), 16'd0);

    // Reset while the operation is in S3
    in_op = 2'b00; in_amount = 4'd3; in_value = 16'h00FF; in_valid = 1'b1;
    @(posedge clk); #1;           // accepted, now S1
    in_valid = 1'b0;
    @(posedge clk); #1;           // now S3
    check("mr_busy_s3", 16'(busy), 16'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mr_out_valid", 16'(out_valid), 16'd0);
    check("mr_result", out_result, 16'h0000);
    check("mr_in_ready", 16'(in_ready), 16'd1);
    check("mr_busy", 16'(busy), 16'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("mr_no_result_c%0d", i), 16'(out_valid), 16'd0);
    end
    launch(2'b11, 4'd7, 16'hBEEF, "mr_pass");
    check("mr_pass_const", out_result, 16'hBEEF);
    take("mr_pass");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
